sd_block_responder: RTL and testbench

//  Target side of the user_io sd_* block protocol: serves 512-byte block read/write requests from an initiator
//  (e.g. the backup-RAM save/load FSM) against a byte-wide backing memory.

---
 rtl/sd_block_responder.sv | 207 ++++++++++++++++++++
 tb/tb_sd_block_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// sd_block_responder
//   Target side of the sd_* block protocol. It serves 512-byte block read and write requests
//   from an initiator against a byte-wide backing memory with a request/ack handshake.
//
// Ports
//   clk_sys_i        system clock
//   reset_i          synchronous, active-high reset; aborts any transfer at once
//   sd_lba_i         block address, sampled when a request is accepted
//   sd_rd_i/sd_wr_i  read/write request levels (read wins if both are high)
//   sd_ack_o         high while the byte transfer runs
//   sd_buff_addr_o   byte index within the block
//   sd_buff_dout_o   read data to the initiator buffer, valid with sd_buff_wr_o
//   sd_buff_wr_o     1-cycle read-data strobe
//   sd_buff_din_i    write data from the initiator, valid 2 cycles after sd_buff_addr_o changes
//   mem_addr_o       {lba, byte} into the backing image
//   mem_rd_o/mem_wr_o 1-cycle memory strobes
//   mem_wdata_o      write data, valid with mem_wr_o
//   mem_rdata_i      read data, valid with mem_ack_i
//   mem_ack_i        1-cycle completion of the outstanding memory access
//   busy_o           high whenever the FSM is not idle
//   lba_err_o        1-cycle pulse on accept of an out-of-range block address
module sd_block_responder #(
  parameter int unsigned LBA_BITS  = 6,
  parameter int unsigned ACK_DELAY = 4
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_i,
  input  logic [31:0]           sd_lba_i,
  input  logic                  sd_rd_i,
  input  logic                  sd_wr_i,
  output logic                  sd_ack_o,
  output logic [8:0]            sd_buff_addr_o,
  output logic [7:0]            sd_buff_dout_o,
  output logic                  sd_buff_wr_o,
  input  logic [7:0]            sd_buff_din_i,
  output logic [LBA_BITS+8:0]   mem_addr_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  lba_err_o
);

  localparam logic [3:0] AckLast    = 4'(ACK_DELAY - 1);
  // Cycles spent in StWrSample before capture: the initiator's buffer needs 2 cycles after
  // the address change, so the capture happens on the third edge.
  localparam logic [3:0] SampleLast = 4'd2;

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StRdIssue,
    StRdWait,
    StWrAddr,
    StWrSample,
    StWrWait,
    StDone
  } state_e;

  state_e                state_q;
  logic [8:0]            cnt_q;
  logic [3:0]            wait_q;
  logic [LBA_BITS-1:0]   lba_q;
  logic                  oor_q;
  logic                  is_rd_q;
  logic                  sd_ack_q;
  logic [8:0]            sd_buff_addr_q;
  logic [7:0]            sd_buff_dout_q;
  logic                  sd_buff_wr_q;
  logic [LBA_BITS+8:0]   mem_addr_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [7:0]            mem_wdata_q;
  logic                  lba_err_q;

  logic                  lba_oor_d;
  logic                  cnt_last_d;

  always_comb begin
    lba_oor_d  = (sd_lba_i >> LBA_BITS) != 32'd0;
    cnt_last_d = (cnt_q == 9'd511);
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wait_q         <= '0;
      lba_q          <= '0;
      oor_q          <= 1'b0;
      is_rd_q        <= 1'b0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= '0;
      sd_buff_dout_q <= '0;
      sd_buff_wr_q   <= 1'b0;
      mem_addr_q     <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_wdata_q    <= '0;
      lba_err_q      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      sd_buff_wr_q <= 1'b0;
      lba_err_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (sd_rd_i || sd_wr_i) begin
            is_rd_q   <= sd_rd_i;
            lba_q     <= sd_lba_i[LBA_BITS-1:0];
            oor_q     <= lba_oor_d;
            lba_err_q <= lba_oor_d;
            cnt_q     <= '0;
            wait_q    <= '0;
            state_q   <= StDelay;
          end
        end

        StDelay: begin
          if (wait_q == AckLast) begin
            sd_ack_q <= 1'b1;
            state_q  <= is_rd_q ? StRdIssue : StWrAddr;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end

        StRdIssue: begin
          mem_addr_q <= {lba_q, cnt_q};
          mem_rd_q   <= !oor_q;
          state_q    <= StRdWait;
        end

        StRdWait: begin
          // Out-of-range blocks never touch memory; the byte completes immediately as 8'hFF.
          if (mem_ack_i || oor_q) begin
            sd_buff_addr_q <= cnt_q;
            sd_buff_dout_q <= oor_q ? 8'hFF : mem_rdata_i;
            sd_buff_wr_q   <= 1'b1;
            cnt_q          <= cnt_q + 9'd1;
            if (cnt_last_d) begin
              sd_ack_q <= 1'b0;
              state_q  <= StDone;
            end else begin
              state_q <= StRdIssue;
            end
          end
        end

        StWrAddr: begin
          sd_buff_addr_q <= cnt_q;
          wait_q         <= '0;
          state_q        <= StWrSample;
        end

        StWrSample: begin
          if (wait_q == SampleLast) begin
            mem_addr_q  <= {lba_q, cnt_q};
            mem_wdata_q <= sd_buff_din_i;
            mem_wr_q    <= !oor_q;
            state_q     <= StWrWait;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end

        StWrWait: begin
          if (mem_ack_i || oor_q) begin
            cnt_q <= cnt_q + 9'd1;
            if (cnt_last_d) begin
              sd_ack_q <= 1'b0;
              state_q  <= StDone;
            end else begin
              state_q <= StWrAddr;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    sd_ack_o       = sd_ack_q;
    sd_buff_addr_o = sd_buff_addr_q;
    sd_buff_dout_o = sd_buff_dout_q;
    sd_buff_wr_o   = sd_buff_wr_q;
    mem_addr_o     = mem_addr_q;
    mem_rd_o       = mem_rd_q;
    mem_wr_o       = mem_wr_q;
    mem_wdata_o    = mem_wdata_q;
    busy_o         = (state_q != StIdle);
    lba_err_o      = lba_err_q;
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized scoreboard bench for sd_block_responder: a behavioural image model predicts every
// buffer strobe and memory strobe; a negedge monitor pops and compares them as they appear.
module tb_sd_block_responder;

  localparam int unsigned LbaBits  = 6;
  localparam int unsigned AckDelay = 4;
  localparam int unsigned Aw       = LbaBits + 9;
  localparam int unsigned MemSize  = 1 << Aw;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [Aw-1:0]     mem_addr;
  logic              mem_rd, mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              lba_err;

  always #5 clk = ~clk;

  sd_block_responder #(
    .LBA_BITS  (LbaBits),
    .ACK_DELAY (AckDelay)
  ) dut (
    .clk_sys_i      (clk),
    .reset_i        (reset),
    .sd_lba_i       (sd_lba),
    .sd_rd_i        (sd_rd),
    .sd_wr_i        (sd_wr),
    .sd_ack_o       (sd_ack),
    .sd_buff_addr_o (sd_buff_addr),
    .sd_buff_dout_o (sd_buff_dout),
    .sd_buff_wr_o   (sd_buff_wr),
    .sd_buff_din_i  (sd_buff_din),
    .mem_addr_o     (mem_addr),
    .mem_rd_o       (mem_rd),
    .mem_wr_o       (mem_wr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mem_ack_i      (mem_ack),
    .busy_o         (busy),
    .lba_err_o      (lba_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] sim_mem [MemSize];  // contents seen by the memory port
  logic [7:0] ref_mem [MemSize];  // expected image contents

  int         mem_lat  = 1;
  logic [7:0] din_seed = 8'h00;
  int         lba_err_seen = 0;

  logic [16:0]   exp_buff [$];  // {byte index, data}
  logic [Aw-1:0] exp_rd   [$];
  logic [Aw+7:0] exp_wr   [$];  // {mem addr, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory model: ack after mem_lat cycles, writes land at the strobe.
  logic          pend = 1'b0;
  int            pcnt;
  logic          p_rd;
  logic [Aw-1:0] p_addr;
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        pend    = 1'b0;
        mem_ack = 1'b1;
        if (p_rd) mem_rdata = sim_mem[p_addr];
      end
    end
    if (mem_rd || mem_wr) begin
      pend   = 1'b1;
      pcnt   = mem_lat;
      p_addr = mem_addr;
      p_rd   = mem_rd;
      if (mem_wr) sim_mem[mem_addr] = mem_wdata;
    end
  end

  // Initiator buffer: data for an address appears 2 cycles after the address changes.
  logic [7:0] din_p1 = 8'h00, din_p2 = 8'h00;
  always @(negedge clk) begin
    sd_buff_din = din_p2;
    din_p2      = din_p1;
    din_p1      = sd_buff_addr[7:0] ^ din_seed;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (sd_buff_wr) begin
      if (exp_buff.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_buff_wr: addr 0x%0h data 0x%0h, expected none", sd_buff_addr,
                 sd_buff_dout);
      end else begin
        check("buff_strobe", {15'd0, sd_buff_addr, sd_buff_dout}, {15'd0, exp_buff.pop_front()});
      end
    end
    if (mem_rd) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_mem_rd: addr 0x%0h, expected none", mem_addr);
      end else begin
        check("mem_rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
      end
    end
    if (mem_wr) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_mem_wr: addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
      end else begin
        check("mem_wr", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
      end
    end
    if (lba_err) lba_err_seen++;
  end

  // One block transfer. abort_at >= 0 asserts reset once the write of that byte is strobed.
  task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] lba, input int lat,
                          input logic [7:0] seed, input int abort_at);
    logic          oor;
    logic [Aw-1:0] base;
    logic [Aw-1:0] a;
    logic [7:0]    d;
    int            n;
    bit            ok;
    oor          = (lba >> LbaBits) != 32'd0;
    base         = Aw'(lba % (1 << LbaBits)) << 9;
    mem_lat      = lat;
    din_seed     = seed;
    lba_err_seen = 0;
    for (int i = 0; i < 512; i++) begin
      a = base + Aw'(i);
      d = 8'(i) ^ seed;
      if (rd) begin
        exp_buff.push_back({9'(i), oor ? 8'hFF : ref_mem[a]});
        if (!oor) exp_rd.push_back(a);
      end else if (!oor) begin
        exp_wr.push_back({a, d});
        if (abort_at < 0 || i <= abort_at) ref_mem[a] = d;
      end
    end

    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    check("accept", 32'(ok), 32'd1);
    check("lba_err_at_accept", 32'(lba_err), 32'(oor));
    n = 0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (sd_ack) begin ok = 1; break; end
      @(negedge clk);
      n++;
    end
    check("ack_delay", 32'(n), 32'(AckDelay));
    sd_rd = 1'b0;
    sd_wr = 1'b0;

    if (abort_at >= 0) begin
      ok = 0;
      for (int k = 0; k < 20000; k++) begin
        @(negedge clk);
        if (mem_wr && mem_addr[8:0] == 9'(abort_at)) begin ok = 1; break; end
      end
      check("abort_reached", 32'(ok), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ack_low", 32'(sd_ack), 32'd0);
      check("abort_busy_low", 32'(busy), 32'd0);
      reset = 1'b0;
      exp_wr.delete();
      repeat (8) @(negedge clk);
    end else begin
      ok = 0;
      for (int k = 0; k < 20000; k++) begin
        @(negedge clk);
        if (!busy) begin ok = 1; break; end
      end
      check("xfer_done", 32'(ok), 32'd1);
      check("ack_low_at_idle", 32'(sd_ack), 32'd0);
      @(negedge clk);
    end
    check("buff_left", 32'(exp_buff.size()), 32'd0);
    check("mem_rd_left", 32'(exp_rd.size()), 32'd0);
    check("mem_wr_left", 32'(exp_wr.size()), 32'd0);
    check("lba_err_count", 32'(lba_err_seen), 32'(oor));
    exp_buff.delete();
    exp_rd.delete();
    exp_wr.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lbas [5];
    logic [7:0]  seeds [5];
    bit          used [64];
    int          l;

    for (int i = 0; i < int'(MemSize); i++) begin
      sim_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    reset  = 1'b1;
    sd_lba = '0;
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sd_ack", 32'(sd_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
    check("rst_buff_addr", 32'(sd_buff_addr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_lba_err", 32'(lba_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_xfer(1'b1, 1'b0, 32'd3, 1, 8'h00, -1);           // plain read
    run_xfer(1'b0, 1'b1, 32'd63, 3, 8'hFF, -1);          // write of ~byte, slow memory
    run_xfer(1'b1, 1'b1, 32'd0, 1, 8'h00, -1);           // read wins over write
    run_xfer(1'b1, 1'b0, 32'd64, 1, 8'h00, -1);          // out-of-range read
    run_xfer(1'b0, 1'b1, 32'd64, 1, 8'h33, -1);          // out-of-range write
    run_xfer(1'b1, 1'b0, 32'h8000_0005, 2, 8'h00, -1);   // high bits set
    run_xfer(1'b0, 1'b1, 32'd2, 3, 8'hA5, 200);          // reset mid-write
    run_xfer(1'b1, 1'b0, 32'd1, 1, 8'h00, -1);
    run_xfer(1'b1, 1'b0, 32'd2, 2, 8'h00, -1);           // partially written block

    foreach (used[i]) used[i] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do l = int'($urandom_range(0, 63)); while (used[l]);
      used[l]  = 1'b1;
      lbas[i]  = l;
      seeds[i] = 8'($urandom);
      run_xfer(1'b0, 1'b1, 32'(l), int'($urandom_range(1, 3)), seeds[i], -1);
    end
    for (int i = 0; i < 5; i++) begin
      run_xfer(1'b1, 1'b0, 32'(lbas[i]), int'($urandom_range(1, 3)), 8'h00, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
